// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   mode_e          : operation select carried on the `sub` port (ADD / SUB)
//   DEFAULT_WIDTH   : default operand/result width
//   DEFAULT_STAGES  : default number of pipeline stages (carry chunks)
//   full_adder()    : one-bit full adder cell used to build the ripple chains
package pipelined_addsub_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder, one instance per pipeline stage.
//   a, b   : chunk operands (b is already inverted for subtraction)
//   cin    : carry into bit 0 of the chunk
//   sum    : chunk sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow on the last chunk)
module addsub_chunk
    import pipelined_addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic carry;

    // The chain is walked inside one process so the carry is a plain
    // sequential variable rather than a self-referencing vector.
    always_comb begin
        carry = cin;
        sum   = '0;
        c_msb = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = carry;
            end
            {carry, sum[i]} = full_adder(a[i], b[i], carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor. The carry chain is split into
// STAGES chunks of CHUNK bits; stage k resolves chunk k and passes its carry,
// the not-yet-used operand bits and the finished result bits to stage k+1.
//   clk, reset          : single clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake (a, b, sub, c_in)
//   out_valid/out_ready : result beat handshake (res, c_out, overflow, zero)
//   sub                 : 0 -> a+b+c_in, 1 -> a-b (c_in ignored)
//   c_out               : carry out of the MSB (subtract: 1 = no borrow)
//   overflow            : two's-complement overflow
//   zero                : res == 0
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    // Stage registers: valid chain, skewed operands, partial result, carry.
    logic             v_r  [STAGES];
    logic [WIDTH-1:0] a_r  [STAGES];
    logic [WIDTH-1:0] b_r  [STAGES];
    logic [WIDTH-1:0] s_r  [STAGES];
    logic             c_r  [STAGES];
    logic             c_msb_r;
    logic             zero_r;

    // Inputs presented to each stage's adder.
    logic             st_v [STAGES];
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];

    logic [CHUNK-1:0] ch_sum  [STAGES];
    logic             ch_cout [STAGES];
    logic             ch_msb  [STAGES];
    logic [WIDTH-1:0] s_next  [STAGES];

    logic advance;
    logic unused_fold;

    // Handshake: a beat moves on a rising edge when valid && ready on that
    // side. The whole pipeline advances together whenever the output slot is
    // empty or being drained (advance); otherwise every stage holds, so the
    // input side is ready exactly when the pipeline advances.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_r[STAGES-1];

    // Stage 0 takes the decoded beat; later stages take the previous registers.
    always_comb begin
        st_v[0] = in_valid;
        st_a[0] = a;
        st_b[0] = (sub == MODE_SUB) ? ~b : b;
        st_c[0] = (sub == MODE_SUB) ? 1'b1 : c_in;
        st_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k] = v_r[k-1];
            st_a[k] = a_r[k-1];
            st_b[k] = b_r[k-1];
            st_c[k] = c_r[k-1];
            st_s[k] = s_r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (st_a[k][k*CHUNK +: CHUNK]),
            .b     (st_b[k][k*CHUNK +: CHUNK]),
            .cin   (st_c[k]),
            .sum   (ch_sum[k]),
            .cout  (ch_cout[k]),
            .c_msb (ch_msb[k])
        );
    end

    // Drop each stage's freshly computed chunk into the forwarded result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next[k] = st_s[k];
            s_next[k][k*CHUNK +: CHUNK] = ch_sum[k];
        end
    end

    // Data registers load only with a valid beat, so outputs stay put once
    // the pipeline drains instead of picking up idle-bus values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
                c_r[k] <= 1'b0;
            end
            c_msb_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= st_v[k];
                if (st_v[k]) begin
                    a_r[k] <= st_a[k];
                    b_r[k] <= st_b[k];
                    s_r[k] <= s_next[k];
                    c_r[k] <= ch_cout[k];
                end
            end
            if (st_v[STAGES-1]) begin
                c_msb_r <= ch_msb[STAGES-1];
                zero_r  <= (s_next[STAGES-1] == '0);
            end
        end
    end

    assign res      = s_r[STAGES-1];
    assign c_out    = c_r[STAGES-1];
    assign overflow = c_msb_r ^ c_r[STAGES-1];
    assign zero     = zero_r;

    // Operand bits already consumed, last-stage operand copies and the
    // per-stage c_msb of inner chunks have no reader; fold them here.
    always_comb begin
        unused_fold = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_fold = unused_fold ^ (^a_r[k]) ^ (^b_r[k]) ^ (^st_a[k]) ^ (^st_b[k])
                        ^ ch_msb[k] ^ ch_cout[k];
        end
    end

endmodule
